// File: rtl/bp_pkg.sv
// Shared types, constants and the 2-bit saturating counter helper for the
// tournament branch predictor.
package bp_pkg;

    localparam int BP_BTB_IDX_W = 4;
    localparam int BP_HIST_W    = 4;
    localparam int BP_TAG_W     = 32 - BP_BTB_IDX_W - 2;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_WEAK_NT      = 2'b01;
    localparam ctr2_t CTR_INIT_CHOOSER = 2'b01;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } bp_state_t;

    typedef struct packed {
        logic                 valid;
        logic                 is_jal;
        logic [BP_TAG_W-1:0]  tag;
        logic [31:0]          target;
        logic [BP_HIST_W-1:0] lhist;
    } btb_entry_t;

    function automatic ctr2_t sat_update(input ctr2_t ctr, input logic taken);
        ctr2_t res;
        res = ctr;
        if (taken) begin
            if (ctr != 2'b11) res = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_ctr_table.sv
// Array of 2-bit saturating counters: combinational read, one training port,
// and a clear port that has priority and writes the init value.
module bp_ctr_table
    import bp_pkg::*;
#(
    parameter int    IDX_W = 4,
    parameter ctr2_t INIT  = CTR_WEAK_NT
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr2_t            rd_ctr,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    localparam int DEPTH = 2 ** IDX_W;

    ctr2_t            mem_q [DEPTH];
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    ctr2_t            wr_val;

    always_comb begin
        wr_en  = clr_en | upd_en;
        wr_idx = upd_idx;
        wr_val = sat_update(mem_q[upd_idx], upd_taken);
        if (clr_en) begin
            wr_idx = clr_idx;
            wr_val = INIT;
        end
    end

    assign rd_ctr = mem_q[rd_idx];

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= wr_val;
    end

endmodule

// File: rtl/bp_update_unit.sv
// Tournament branch predictor: BTB + local/global PHTs + chooser + GHR, with a
// clear walk after reset. Optional event counters under `BP_STATS_EN`.
module bp_update_unit
    import bp_pkg::*;
#(
    parameter int BTB_IDX_W = BP_BTB_IDX_W,
    parameter int HIST_W    = BP_HIST_W,
    parameter int TAG_W     = BP_TAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       if_pc,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic              pred_hit,
    output logic [HIST_W-1:0] pred_pattern_used,
    output logic              pred_local,
    output logic              pred_global,
    output logic              pred_is_jal,
    input  logic              mem_advance,
    input  logic [31:0]       mem_pc,
    input  logic [31:0]       mem_jmp_pc,
    input  logic              mem_pc_mux_sel,
    input  logic              mem_update_bht,
    input  logic              mem_replace_bht,
    input  logic [HIST_W-1:0] mem_pattern_used,
    input  logic              mem_is_jal,
    input  logic              mem_local_prediction,
    input  logic              mem_global_prediction,
    output logic              ready
`ifdef BP_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_local_ok,
    output logic [31:0]       stat_global_ok
`endif
);

    localparam int BTB_N = 2 ** BTB_IDX_W;
    localparam int PHT_N = 2 ** HIST_W;
    localparam int CLR_N = (BTB_N > PHT_N) ? BTB_N : PHT_N;
    localparam int CLR_W = $clog2(CLR_N) + 1;

    bp_state_t         state_q, state_d;
    logic [CLR_W-1:0]  clr_idx_q, clr_idx_d;
    logic [HIST_W-1:0] ghr_q, ghr_d;
    btb_entry_t        btb_q [BTB_N];

    logic running, clearing, clr_btb, clr_pht;

    assign running  = (state_q == ST_RUN);
    assign clearing = (state_q == ST_CLEAR) && (clr_idx_q < CLR_W'(CLR_N));
    assign clr_btb  = clearing && (clr_idx_q < CLR_W'(BTB_N));
    assign clr_pht  = clearing && (clr_idx_q < CLR_W'(PHT_N));
    assign ready    = running;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            // One spare cycle after the last index write before RUN.
            if (clr_idx_q == CLR_W'(CLR_N)) state_d = ST_RUN;
            else                            clr_idx_d = clr_idx_q + 1'b1;
        end
    end

    // Fetch-side lookup.
    logic [BTB_IDX_W-1:0] if_idx;
    logic [TAG_W-1:0]     if_tag;
    btb_entry_t           if_entry;
    logic                 if_hit;
    ctr2_t                lpht_rd, gpht_rd, chooser_rd;
    logic                 sel_taken;

    assign if_idx   = if_pc[BTB_IDX_W+1:2];
    assign if_tag   = if_pc[31:32-TAG_W];
    assign if_entry = btb_q[if_idx];
    assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);
    assign sel_taken = chooser_rd[1] ? gpht_rd[1] : lpht_rd[1];

    always_comb begin
        pred_taken        = 1'b0;
        pred_target       = if_pc + 32'd4;
        pred_hit          = 1'b0;
        pred_pattern_used = '0;
        pred_local        = 1'b0;
        pred_global       = 1'b0;
        pred_is_jal       = 1'b0;
        if (running) begin
            pred_hit          = if_hit;
            pred_local        = lpht_rd[1];
            pred_global       = gpht_rd[1];
            pred_is_jal       = if_hit && if_entry.is_jal;
            pred_pattern_used = ghr_q;
            pred_taken        = if_hit && (if_entry.is_jal || sel_taken);
            if (if_hit && (if_entry.is_jal || sel_taken)) pred_target = if_entry.target;
        end
    end

    // MEM-side training. Gated on !reset so the reset edge never trains.
    logic [BTB_IDX_W-1:0] mem_idx;
    btb_entry_t           mem_entry;
    logic                 upd_go, do_replace, do_cond, do_jal, shift_ghr;
    logic                 btb_wr_en;
    logic [BTB_IDX_W-1:0] btb_wr_idx;
    btb_entry_t           btb_wr_entry;
    logic                 unused_bits;

    assign mem_idx     = mem_pc[BTB_IDX_W+1:2];
    assign mem_entry   = btb_q[mem_idx];
    assign upd_go      = running && mem_advance && !reset;
    assign do_replace  = upd_go && mem_replace_bht;
    assign do_cond     = upd_go && !mem_replace_bht && mem_update_bht && !mem_is_jal;
    assign do_jal      = upd_go && !mem_replace_bht && mem_update_bht && mem_is_jal;
    assign shift_ghr   = (do_replace && !mem_is_jal) || do_cond;
    assign unused_bits = ^{mem_pc[1:0]};

    always_comb begin
        ghr_d = ghr_q;
        if (shift_ghr) ghr_d = {ghr_q[HIST_W-2:0], mem_pc_mux_sel};
    end

    always_comb begin
        btb_wr_en    = 1'b0;
        btb_wr_idx   = mem_idx;
        btb_wr_entry = mem_entry;
        if (clr_btb) begin
            btb_wr_en    = 1'b1;
            btb_wr_idx   = clr_idx_q[BTB_IDX_W-1:0];
            btb_wr_entry = '0;
        end else if (do_replace) begin
            btb_wr_en           = 1'b1;
            btb_wr_entry.valid  = 1'b1;
            btb_wr_entry.is_jal = mem_is_jal;
            btb_wr_entry.tag    = mem_pc[31:32-TAG_W];
            btb_wr_entry.target = mem_jmp_pc;
            btb_wr_entry.lhist  = '0;
        end else if (do_cond) begin
            btb_wr_en          = 1'b1;
            btb_wr_entry.lhist = {mem_entry.lhist[HIST_W-2:0], mem_pc_mux_sel};
            if (mem_pc_mux_sel) btb_wr_entry.target = mem_jmp_pc;
        end else if (do_jal) begin
            btb_wr_en           = 1'b1;
            btb_wr_entry.target = mem_jmp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            ghr_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ghr_q     <= ghr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_wr_en) btb_q[btb_wr_idx] <= btb_wr_entry;
    end

    bp_ctr_table #(.IDX_W(HIST_W), .INIT(CTR_WEAK_NT)) u_lpht (
        .clk       (clk),
        .rd_idx    (if_entry.lhist),
        .rd_ctr    (lpht_rd),
        .upd_en    (do_cond),
        .upd_idx   (mem_entry.lhist),
        .upd_taken (mem_pc_mux_sel),
        .clr_en    (clr_pht),
        .clr_idx   (clr_idx_q[HIST_W-1:0])
    );

    bp_ctr_table #(.IDX_W(HIST_W), .INIT(CTR_WEAK_NT)) u_gpht (
        .clk       (clk),
        .rd_idx    (ghr_q ^ if_pc[HIST_W+1:2]),
        .rd_ctr    (gpht_rd),
        .upd_en    (do_cond),
        .upd_idx   (mem_pattern_used ^ mem_pc[HIST_W+1:2]),
        .upd_taken (mem_pc_mux_sel),
        .clr_en    (clr_pht),
        .clr_idx   (clr_idx_q[HIST_W-1:0])
    );

    // Chooser is per BTB slot; it only learns when the two predictors disagreed.
    bp_ctr_table #(.IDX_W(BTB_IDX_W), .INIT(CTR_INIT_CHOOSER)) u_chooser (
        .clk       (clk),
        .rd_idx    (if_idx),
        .rd_ctr    (chooser_rd),
        .upd_en    (do_cond && (mem_local_prediction != mem_global_prediction)),
        .upd_idx   (mem_idx),
        .upd_taken (mem_global_prediction == mem_pc_mux_sel),
        .clr_en    (clr_btb),
        .clr_idx   (clr_idx_q[BTB_IDX_W-1:0])
    );

`ifdef BP_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_local_ok_q, stat_local_ok_d;
    logic [31:0] stat_global_ok_q, stat_global_ok_d;

    always_comb begin
        stat_branches_d  = stat_branches_q;
        stat_local_ok_d  = stat_local_ok_q;
        stat_global_ok_d = stat_global_ok_q;
        if (!running) begin
            stat_branches_d  = '0;
            stat_local_ok_d  = '0;
            stat_global_ok_d = '0;
        end else if (do_cond) begin
            stat_branches_d = stat_branches_q + 32'd1;
            if (mem_local_prediction == mem_pc_mux_sel)  stat_local_ok_d  = stat_local_ok_q + 32'd1;
            if (mem_global_prediction == mem_pc_mux_sel) stat_global_ok_d = stat_global_ok_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_branches_q  <= '0;
            stat_local_ok_q  <= '0;
            stat_global_ok_q <= '0;
        end else begin
            stat_branches_q  <= stat_branches_d;
            stat_local_ok_q  <= stat_local_ok_d;
            stat_global_ok_q <= stat_global_ok_d;
        end
    end

    assign stat_branches  = stat_branches_q;
    assign stat_local_ok  = stat_local_ok_q;
    assign stat_global_ok = stat_global_ok_q;
`endif

endmodule

// File: tb/tb_bp_update_unit.sv
// Scoreboard bench for bp_update_unit: directed scenarios then random traffic,
// every cycle checked against a table-level model of the predictor.
module tb_bp_update_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken, pred_hit, pred_local, pred_global, pred_is_jal, ready;
    logic [31:0] pred_target;
    logic [3:0]  pred_pattern_used;
    logic        mem_advance, mem_pc_mux_sel, mem_update_bht, mem_replace_bht, mem_is_jal;
    logic        mem_local_prediction, mem_global_prediction;
    logic [31:0] mem_pc, mem_jmp_pc;
    logic [3:0]  mem_pattern_used;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches, stat_local_ok, stat_global_ok;
`endif

    always #5 clk = ~clk;

    bp_update_unit dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
        .pred_pattern_used(pred_pattern_used), .pred_local(pred_local),
        .pred_global(pred_global), .pred_is_jal(pred_is_jal),
        .mem_advance(mem_advance), .mem_pc(mem_pc), .mem_jmp_pc(mem_jmp_pc),
        .mem_pc_mux_sel(mem_pc_mux_sel), .mem_update_bht(mem_update_bht),
        .mem_replace_bht(mem_replace_bht), .mem_pattern_used(mem_pattern_used),
        .mem_is_jal(mem_is_jal), .mem_local_prediction(mem_local_prediction),
        .mem_global_prediction(mem_global_prediction), .ready(ready)
`ifdef BP_STATS_EN
        , .stat_branches(stat_branches), .stat_local_ok(stat_local_ok),
        .stat_global_ok(stat_global_ok)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays of counters/entries indexed per the predictor rules.
    bit          m_valid [16];
    bit          m_jal   [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_lh    [16];
    int          m_lpht  [16];
    int          m_gpht  [16];
    int          m_ch    [16];
    int          m_ghr   = 0;
    int          m_edges = 0;

    typedef struct packed {
        logic        rdy, hit, tkn;
        logic [31:0] tgt;
        logic [3:0]  pat;
        logic        loc, glo, jal;
    } exp_t;

    exp_t sb_q[$];

    function automatic int sat(input int c, input bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic exp_t predict(input logic [31:0] pc);
        exp_t e;
        int   i, g;
        bit   sel;
        e = '0;
        e.tgt = pc + 32'd4;
        if (m_edges < 17) return e;
        i = int'(pc[5:2]);
        g = (m_ghr ^ int'(pc[5:2])) & 15;
        e.rdy = 1'b1;
        e.hit = m_valid[i] && (m_tag[i] == pc[31:6]);
        e.loc = (m_lpht[m_lh[i]] >= 2);
        e.glo = (m_gpht[g] >= 2);
        e.pat = 4'(m_ghr);
        e.jal = e.hit && m_jal[i];
        sel   = (m_ch[i] >= 2) ? e.glo : e.loc;
        e.tkn = e.hit && (m_jal[i] || sel);
        if (e.tkn) e.tgt = m_tgt[i];
        return e;
    endfunction

    task automatic model_edge();
        int i, g;
        bit t;
        if (reset) begin
            m_edges = 0;
            m_ghr   = 0;
            for (int k = 0; k < 16; k++) begin
                m_valid[k] = 0; m_lh[k] = 0; m_lpht[k] = 1; m_gpht[k] = 1; m_ch[k] = 1;
            end
            return;
        end
        if (m_edges >= 17 && mem_advance) begin
            i = int'(mem_pc[5:2]);
            t = mem_pc_mux_sel;
            if (mem_replace_bht) begin
                m_valid[i] = 1; m_jal[i] = mem_is_jal; m_tag[i] = mem_pc[31:6];
                m_tgt[i] = mem_jmp_pc; m_lh[i] = 0;
                if (!mem_is_jal) m_ghr = ((m_ghr << 1) | int'(t)) & 15;
            end else if (mem_update_bht && mem_is_jal) begin
                m_tgt[i] = mem_jmp_pc;
            end else if (mem_update_bht) begin
                g = int'(mem_pattern_used ^ mem_pc[5:2]);
                m_lpht[m_lh[i]] = sat(m_lpht[m_lh[i]], t);
                m_gpht[g] = sat(m_gpht[g], t);
                m_lh[i] = ((m_lh[i] << 1) | int'(t)) & 15;
                if (t) m_tgt[i] = mem_jmp_pc;
                if (mem_local_prediction != mem_global_prediction)
                    m_ch[i] = sat(m_ch[i], mem_global_prediction == t);
                m_ghr = ((m_ghr << 1) | int'(t)) & 15;
            end
        end
        if (m_edges < 17) m_edges++;
    endtask

    task automatic drive(input logic rst, input logic [31:0] pc, input logic adv,
                         input logic repl, input logic upd, input logic jal, input logic tkn,
                         input logic [31:0] mpc, input logic [31:0] jmp, input logic [3:0] pat,
                         input logic lp, input logic gp);
        reset = rst; if_pc = pc; mem_advance = adv; mem_replace_bht = repl;
        mem_update_bht = upd; mem_is_jal = jal; mem_pc_mux_sel = tkn; mem_pc = mpc;
        mem_jmp_pc = jmp; mem_pattern_used = pat; mem_local_prediction = lp;
        mem_global_prediction = gp;
        if (!rst) sb_q.push_back(predict(pc));
    endtask

    task automatic idle(input logic [31:0] pc);
        drive(0, pc, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h0000_0000;
            1:       base = 32'h0000_1000;
            default: base = 32'h0002_0000;
        endcase
        return base | (32'($urandom_range(0, 15)) << 2);
    endfunction

    // Monitor: each cycle the bench issued a prediction request, compare it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_ready",  32'(ready),             32'(e.rdy));
                chk("sb_hit",    32'(pred_hit),          32'(e.hit));
                chk("sb_taken",  32'(pred_taken),        32'(e.tkn));
                chk("sb_target", pred_target,            e.tgt);
                chk("sb_pattern",32'(pred_pattern_used), 32'(e.pat));
                chk("sb_local",  32'(pred_local),        32'(e.loc));
                chk("sb_global", 32'(pred_global),       32'(e.glo));
                chk("sb_is_jal", 32'(pred_is_jal),       32'(e.jal));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic clear_walk(input bit strobes);
        for (int c = 0; c <= 17; c++) begin
            if (strobes && c < 17)
                drive(0, 32'h40, 1, 1, 1, 0, 1, 32'h40, 32'h80, 4'h0, 1, 0);
            else if (c < 17)
                idle(rand_pc());
            else
                idle(32'h40);
            @(negedge clk);
            chk("walk_ready", 32'(ready), (c == 17) ? 32'd1 : 32'd0);
            chk("walk_hit", 32'(pred_hit), 32'd0);
            if (c < 17) chk("walk_target", pred_target, if_pc + 32'd4);
            step();
        end
    endtask

    initial begin
        drive(1, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);
        step();
        step();
        clear_walk(0);

        // Conditional allocate at 0x40: counters still weak not-taken.
        drive(0, 32'h40, 1, 1, 0, 0, 0, 32'h40, 32'h80, 4'h0, 0, 0);
        step();
        idle(32'h40);
        @(negedge clk);
        chk("alloc_hit", 32'(pred_hit), 32'd1);
        chk("alloc_taken", 32'(pred_taken), 32'd0);
        chk("alloc_target", pred_target, 32'h44);
        step();

        // Five taken trainings walk local history to 1111 and GHR to 1111.
        for (int k = 0; k < 5; k++) begin
            drive(0, 32'h40, 1, 0, 1, 0, 1, 32'h40, 32'h80, 4'((1 << k) - 1), 0, 0);
            step();
        end
        idle(32'h40);
        @(negedge clk);
        chk("trained_taken", 32'(pred_taken), 32'd1);
        chk("trained_target", pred_target, 32'h80);
        chk("trained_ghr", 32'(pred_pattern_used), 32'hF);
        step();

        // JAL allocate aliases slot 0; must not shift the GHR.
        drive(0, 32'h100, 1, 1, 0, 1, 1, 32'h100, 32'h200, 4'hF, 0, 0);
        step();
        idle(32'h100);
        @(negedge clk);
        chk("jal_taken", 32'(pred_taken), 32'd1);
        chk("jal_target", pred_target, 32'h200);
        chk("jal_is_jal", 32'(pred_is_jal), 32'd1);
        chk("jal_ghr", 32'(pred_pattern_used), 32'hF);
        step();

        drive(0, 32'h44, 1, 1, 0, 0, 0, 32'h44, 32'h48, 4'hF, 0, 0);
        step();
        idle(32'h44);
        @(negedge clk);
        chk("cond_repl_hit", 32'(pred_hit), 32'd1);
        chk("cond_repl_ghr", 32'(pred_pattern_used), 32'hE);
        step();

        // Stalled MEM stage holds an update for five cycles.
        for (int k = 0; k < 5; k++) begin
            drive(0, 32'h44, 0, 0, 1, 0, 1, 32'h44, 32'h48, 4'hE, 0, 1);
            step();
        end
        idle(32'h44);
        @(negedge clk);
        chk("stall_ghr", 32'(pred_pattern_used), 32'hE);
        step();
        drive(0, 32'h44, 1, 0, 1, 0, 1, 32'h44, 32'h48, 4'hE, 0, 1);
        step();
        idle(32'h44);
        @(negedge clk);
        chk("release_ghr", 32'(pred_pattern_used), 32'hD);
        step();

        // Reset again, interrupt the walk at idx 7, strobe MEM during clear.
        drive(1, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);
        step();
        for (int k = 0; k < 7; k++) begin
            drive(0, 32'h40, 1, 1, 1, 0, 1, 32'h40, 32'h80, 4'h0, 1, 0);
            step();
        end
        drive(1, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0);
        step();
        clear_walk(1);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            logic [31:0] mpc;
            mpc = rand_pc();
            drive(0, rand_pc(), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 1) == 1), mpc, rand_pc(), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
            step();
        end

        idle(32'h0);
        @(negedge clk);
        #1;
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
